// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the uart transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    HI,
    LO
  } tx_arb_state_t;

  localparam int UART_PUSH_HOLD = 2;
  localparam int UART_PUSH_GAP  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-one search: finds the first set bit of valid at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  int           sum;

  // Rotate the request vector so that bit 0 corresponds to the pointer position.
  assign rot = N'({valid, valid} >> ptr);

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        found = 1'b1;
        idx   = W'(sum);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, frame-locked arbiter feeding one uart transmit FIFO through
// the edge-detected push protocol.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = UART_PUSH_HOLD,
  parameter int GAP  = UART_PUSH_GAP,
  parameter int GW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  input  logic [N-1:0]   req_valid,
  input  logic [N*8-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  input  logic           wfull,
  output logic [7:0]     wchar,
  output logic           push,
  output logic [GW-1:0]  grant,
  output logic           busy
);

  localparam int CW = $clog2(max_int(HOLD, GAP) + 1);

  tx_arb_state_t state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] next_ptr;
  logic [CW-1:0] cnt;
  logic          last_q;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [7:0]    lane_data;
  logic          lane_valid;
  logic          lane_last;

  rr_pick #(
    .N(N),
    .W(GW)
  ) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Select the byte lane, valid and last flag of the current owner.
  always_comb begin
    lane_data  = 8'h00;
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == GW'(i)) begin
        lane_data  = req_data[8*i +: 8];
        lane_valid = req_valid[i];
        lane_last  = req_last[i];
      end
    end
  end

  // Pointer just past the owner, wrapping at N even when N is not a power of two.
  always_comb begin
    next_ptr = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
  end

  // Main sequencer; one shared down-counter times both the high and low push phases.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      push      <= 1'b0;
      wchar     <= 8'h00;
      req_ready <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (en && pick_found) begin
            grant <= pick_idx;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (en && !wfull && lane_valid) begin
            wchar            <= lane_data;
            last_q           <= lane_last;
            req_ready[grant] <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          push  <= 1'b1;
          cnt   <= CW'(HOLD - 1);
          state <= HI;
        end
        HI: begin
          if (cnt == '0) begin
            push  <= 1'b0;
            cnt   <= CW'(GAP - 1);
            state <= LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LO: begin
          if (cnt == '0) begin
            if (last_q) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
